tb_mmio_split: RTL and testbench

Address-decoding splitter between the AXI-to-memory bridge's single-port request interface and the testbench SRAM. Requests hitting a configurable MMIO window go to a small testbench register block: 32-bit scratch registers, a sticky exit/tohost register and an optional cycle counter. All other requests pass unchanged to the SRAM. Read data is merged back with the SRAM's one-cycle read latency, so the bridge sees one uniform memory.

---
 rtl/tb_mmio_split.sv | 201 ++++++++++++++++++++
 tb/tb_tb_mmio_split.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mmio_split.sv
// tb_mmio_split
//   Steers single-port memory requests from the AXI-to-memory bridge either to
//   the testbench SRAM or to a small register block inside an MMIO window.
//   The register block contains:
//     - NUM_REGS 32-bit scratch registers, packed two per 64-bit word
//     - a sticky exit/tohost register
//     - an optional free-running cycle counter
//   Read data from the register block is delayed by one cycle to match the
//   SRAM's read latency. The bridge therefore sees one uniform memory.
//
// Optional feature macro: TB_MMIO_CYCLE_COUNTER_EN
//   When defined, a 64-bit cycle counter is readable at EXIT_OFFSET+8.
//   The counter stops advancing once the exit register has been written.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i, we_i            request / write enable from the bridge
//   addr_i, be_i, wdata_i  byte address, byte enables, write data
//   rdata_o                read data, valid the cycle after a read request
//   mem_req_o, mem_we_o    request / write enable to the SRAM
//   mem_addr_o, mem_be_o,
//   mem_wdata_o            pass-through of addr_i / be_i / wdata_i
//   mem_rdata_i            SRAM read data
//   exit_valid_o           sticky, set by the first exit write
//   exit_code_o            value captured by the exit write
//   mmio_err_o             sticky, set by an access to an unmapped window offset
module tb_mmio_split #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 'h1100_0000,
    parameter logic [ADDR_WIDTH-1:0] MMIO_SIZE   = 'h8000,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] EXIT_OFFSET = 'h4000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    exit_valid_o,
    output logic [31:0]             exit_code_o,
    output logic                    mmio_err_o
);

    localparam int OFF_W  = $clog2(MMIO_SIZE);
    localparam int WOFF_W = OFF_W - 3;
    localparam int NWORDS = NUM_REGS / 2;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [ADDR_WIDTH-1:0] WIN_MASK  = ~(MMIO_SIZE - 1'b1);
    localparam logic [WOFF_W-1:0]     SCR_END   = WOFF_W'(NWORDS);
    localparam logic [WOFF_W-1:0]     EXIT_WORD = EXIT_OFFSET[OFF_W-1:3];
`ifdef TB_MMIO_CYCLE_COUNTER_EN
    localparam logic [WOFF_W-1:0]     CNT_WORD  = EXIT_WORD + WOFF_W'(1);
`endif

    logic                  hit;
    logic [WOFF_W-1:0]     word_off;
    logic [IDX_W-1:0]      scr_idx;
    logic                  scr_sel;
    logic                  exit_sel;
    logic                  unmapped;
    logic                  rd_req;
    logic                  wr_hit;
    logic [DATA_WIDTH-1:0] rd_val;

    logic [DATA_WIDTH-1:0] scratch_q [NWORDS];
    logic                  exit_valid_q, exit_valid_d;
    logic [31:0]           exit_code_q, exit_code_d;
    logic                  err_q, err_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] mmio_rdata_q, mmio_rdata_d;
`ifdef TB_MMIO_CYCLE_COUNTER_EN
    logic                  cnt_sel;
    logic [63:0]           cnt_q, cnt_d;
`endif

    // Decode: registers are addressed by 64-bit word; the low three address
    // bits only matter through the byte enables.
    assign hit      = req_i && ((addr_i & WIN_MASK) == MMIO_BASE);
    assign word_off = addr_i[OFF_W-1:3];
    assign scr_idx  = word_off[IDX_W-1:0];
    assign scr_sel  = (word_off < SCR_END);
    assign exit_sel = (word_off == EXIT_WORD);
`ifdef TB_MMIO_CYCLE_COUNTER_EN
    assign cnt_sel  = (word_off == CNT_WORD);
`endif
    assign rd_req   = req_i && !we_i;
    assign wr_hit   = hit && we_i;

    // Memory path is purely combinational.
    assign mem_req_o   = req_i && !hit;
    assign mem_we_o    = we_i;
    assign mem_addr_o  = addr_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = wdata_i;

    always_comb begin
        rd_val   = '0;
        unmapped = 1'b0;
        if (scr_sel) begin
            rd_val = scratch_q[scr_idx];
        end else if (exit_sel) begin
            rd_val = {31'b0, exit_valid_q, exit_code_q};
`ifdef TB_MMIO_CYCLE_COUNTER_EN
        end else if (cnt_sel) begin
            rd_val = cnt_q;
`endif
        end else begin
            unmapped = 1'b1;
        end
    end

    always_comb begin
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        err_d        = err_q;
        sel_d        = sel_q;
        mmio_rdata_d = mmio_rdata_q;

        // Only the first exit write counts; later ones are ignored until reset.
        if (wr_hit && exit_sel && (|be_i[3:0]) && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_code_d  = wdata_i[31:0];
        end
        if (hit && unmapped) begin
            err_d = 1'b1;
        end
        // The read source and data are held until the next read request,
        // mirroring an SRAM that keeps its last read word.
        if (rd_req) begin
            sel_d = hit;
            if (hit) begin
                mmio_rdata_d = rd_val;
            end
        end
    end

`ifdef TB_MMIO_CYCLE_COUNTER_EN
    // The counter stops on the same edge that accepts the exit write.
    always_comb begin
        cnt_d = cnt_q;
        if (!exit_valid_d) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
            err_q        <= 1'b0;
            sel_q        <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
            err_q        <= err_d;
            sel_q        <= sel_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NWORDS; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (wr_hit && scr_sel) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (be_i[b]) begin
                    scratch_q[scr_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o      = sel_q ? mmio_rdata_q : mem_rdata_i;
    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;
    assign mmio_err_o   = err_q;

endmodule

// File: tb/tb_tb_mmio_split.sv
// Directed bench for tb_mmio_split. A behavioural SRAM with one-cycle read
// latency sits behind the memory port; word 0 is preloaded.
module tb_tb_mmio_split;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        mmio_err;

    int n_vec = 0;
    int n_err = 0;

    tb_mmio_split dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .be_i         (be),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .exit_valid_o (exit_valid),
        .exit_code_o  (exit_code),
        .mmio_err_o   (mmio_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM, keyed by 64-bit word address.
    logic [63:0] sram [logic [60:0]];
    initial mem_rdata = '0;
    always @(posedge clk) begin : sram_model
        logic [63:0] cur;
        if (mem_req) begin
            cur = sram.exists(mem_addr[63:3]) ? sram[mem_addr[63:3]] : 64'h0;
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                sram[mem_addr[63:3]] = cur;
            end else begin
                mem_rdata <= cur;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request at posedge+1, checks the memory-side request
    // decision, and returns at 1 time unit after the edge that accepts it.
    task automatic issue(input logic w, input logic [63:0] a, input logic [7:0] b,
                         input logic [63:0] d, input logic exp_mreq, input string tag);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        chk({tag, ".mem_req"}, {63'b0, mem_req}, {63'b0, exp_mreq});
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef TB_MMIO_CYCLE_COUNTER_EN
    logic [63:0] c1, c2;
`endif

    initial begin
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; rst_n = 1'b0;
        sram[61'h0] = 64'h00000113_00000093;
        do_reset();

        // Reset state
        chk("rst.rdata",      rdata,                64'h0);
        chk("rst.exit_valid", {63'b0, exit_valid},  64'h0);
        chk("rst.exit_code",  {32'b0, exit_code},   64'h0);
        chk("rst.err",        {63'b0, mmio_err},    64'h0);
        chk("rst.mem_req",    {63'b0, mem_req},     64'h0);

        // SRAM write then read-back through the pass-through path
        req = 1'b1; we = 1'b1; addr = 64'h1_0000; be = 8'hFF; wdata = 64'hDEAD_BEEF_0000_0539;
        #1;
        chk("sram_wr.mem_we",    {63'b0, mem_we}, 64'h1);
        chk("sram_wr.mem_addr",  mem_addr,        64'h1_0000);
        chk("sram_wr.mem_be",    {56'b0, mem_be}, 64'hFF);
        chk("sram_wr.mem_wdata", mem_wdata,       64'hDEAD_BEEF_0000_0539);
        #1; req = 1'b0;
        @(posedge clk); #1;
        issue(1'b1, 64'h1_0000, 8'hFF, 64'hDEAD_BEEF_0000_0539, 1'b1, "sram_wr");
        issue(1'b0, 64'h1_0000, 8'hFF, 64'h0, 1'b1, "sram_rd");
        chk("sram_rd.rdata", rdata, 64'hDEAD_BEEF_0000_0539);

        // Scratch register 3 via upper lanes, read back as word 1
        issue(1'b1, 64'h1100_000C, 8'hF0, 64'h0000_002A_0000_0000, 1'b0, "reg3_wr");
        issue(1'b0, 64'h1100_0008, 8'hFF, 64'h0, 1'b0, "reg3_rd");
        chk("reg3_rd.rdata", rdata, 64'h0000_002A_0000_0000);

        // Word 0 full write then partial write of the low two bytes
        issue(1'b1, 64'h1100_0000, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0, "w0_wr");
        issue(1'b1, 64'h1100_0000, 8'h03, 64'h1111_1111_1111_AAAA, 1'b0, "w0_part");
        issue(1'b0, 64'h1100_0000, 8'hFF, 64'h0, 1'b0, "w0_rd");
        chk("w0_rd.rdata", rdata, 64'hCAFE_F00D_1234_AAAA);

        // Last scratch word (registers 14/15)
        issue(1'b1, 64'h1100_0038, 8'hFF, 64'h7777_6666_5555_4444, 1'b0, "w7_wr");
        issue(1'b0, 64'h1100_0038, 8'hFF, 64'h0, 1'b0, "w7_rd");
        chk("w7_rd.rdata", rdata, 64'h7777_6666_5555_4444);
        chk("w7.err", {63'b0, mmio_err}, 64'h0);

        // Exit write with only upper lanes enabled must not trigger
        issue(1'b1, 64'h1100_4000, 8'hF0, 64'h0000_0007_0000_0007, 1'b0, "exit_hi");
        chk("exit_hi.valid", {63'b0, exit_valid}, 64'h0);
        issue(1'b1, 64'h1100_4000, 8'h0F, 64'h1, 1'b0, "exit1");
        chk("exit1.valid", {63'b0, exit_valid}, 64'h1);
        chk("exit1.code",  {32'b0, exit_code},  64'h1);
        issue(1'b1, 64'h1100_4000, 8'h0F, 64'h5, 1'b0, "exit5");
        chk("exit5.valid", {63'b0, exit_valid}, 64'h1);
        chk("exit5.code",  {32'b0, exit_code},  64'h1);
        issue(1'b0, 64'h1100_4000, 8'hFF, 64'h0, 1'b0, "exit_rd");
        chk("exit_rd.rdata", rdata, 64'h0000_0001_0000_0001);
        chk("exit.err", {63'b0, mmio_err}, 64'h0);

        // Back-to-back alternation SRAM / MMIO, no bubbles
        issue(1'b0, 64'h0, 8'hFF, 64'h0, 1'b1, "alt0");
        chk("alt0.rdata", rdata, 64'h00000113_00000093);
        issue(1'b0, 64'h1100_0000, 8'hFF, 64'h0, 1'b0, "alt1");
        chk("alt1.rdata", rdata, 64'hCAFE_F00D_1234_AAAA);
        issue(1'b0, 64'h0, 8'hFF, 64'h0, 1'b1, "alt2");
        chk("alt2.rdata", rdata, 64'h00000113_00000093);
        issue(1'b0, 64'h1100_0000, 8'hFF, 64'h0, 1'b0, "alt3");
        chk("alt3.rdata", rdata, 64'hCAFE_F00D_1234_AAAA);

        // An SRAM write must not move the read select away from MMIO
        issue(1'b1, 64'h1_0000, 8'hFF, 64'h0, 1'b1, "hold_wr");
        chk("hold_wr.rdata", rdata, 64'hCAFE_F00D_1234_AAAA);
        issue(1'b0, 64'h0, 8'hFF, 64'h0, 1'b1, "hold_back");
        chk("hold_back.rdata", rdata, 64'h00000113_00000093);

        // First unmapped offset right after the scratch array
        issue(1'b0, 64'h1100_0040, 8'hFF, 64'h0, 1'b0, "unm40");
        chk("unm40.rdata", rdata, 64'h0);
        chk("unm40.err", {63'b0, mmio_err}, 64'h1);

        // Reset, then unmapped read in the middle of the window
        do_reset();
        chk("rst2.err", {63'b0, mmio_err}, 64'h0);
        issue(1'b1, 64'h1100_2000, 8'hFF, 64'h1234, 1'b0, "unm_wr");
        chk("unm_wr.err", {63'b0, mmio_err}, 64'h1);
        issue(1'b0, 64'h1100_2000, 8'hFF, 64'h0, 1'b0, "unm_rd");
        chk("unm_rd.rdata", rdata, 64'h0);
        issue(1'b1, 64'h1100_4000, 8'h0F, 64'h9, 1'b0, "exit9");
        chk("exit9.code", {32'b0, exit_code}, 64'h9);

        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("arst.exit_valid", {63'b0, exit_valid}, 64'h0);
        chk("arst.exit_code",  {32'b0, exit_code},  64'h0);
        chk("arst.err",        {63'b0, mmio_err},   64'h0);
        chk("arst.rdata",      rdata,               64'h00000113_00000093);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 64'h1100_0000, 8'hFF, 64'h0, 1'b0, "arst_w0");
        chk("arst_w0.rdata", rdata, 64'h0);

`ifdef TB_MMIO_CYCLE_COUNTER_EN
        issue(1'b0, 64'h1100_4008, 8'hFF, 64'h0, 1'b0, "cnt_a");
        c1 = rdata;
        repeat (9) @(posedge clk);
        #1;
        issue(1'b0, 64'h1100_4008, 8'hFF, 64'h0, 1'b0, "cnt_b");
        c2 = rdata;
        chk("cnt.delta", c2 - c1, 64'd10);
        issue(1'b1, 64'h1100_4008, 8'hFF, 64'hFFFF, 1'b0, "cnt_wr");
        chk("cnt_wr.err", {63'b0, mmio_err}, 64'h0);
        issue(1'b1, 64'h1100_4000, 8'h0F, 64'h3, 1'b0, "cnt_exit");
        issue(1'b0, 64'h1100_4008, 8'hFF, 64'h0, 1'b0, "cnt_f1");
        c1 = rdata;
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, 64'h1100_4008, 8'hFF, 64'h0, 1'b0, "cnt_f2");
        chk("cnt.frozen", rdata, c1);
        chk("cnt.nonzero", {63'b0, (c1 > 64'd10)}, 64'h1);
`else
        issue(1'b0, 64'h1100_4008, 8'hFF, 64'h0, 1'b0, "nocnt");
        chk("nocnt.rdata", rdata, 64'h0);
        chk("nocnt.err", {63'b0, mmio_err}, 64'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
